// File: rtl/debounce_pkg.sv
`default_nettype none
// ============================================================================
// Module      : debounce_pkg
// Description : Shared state encodings, default constants and helpers for the
//               push-button debouncer and its synchronizer.
// Revision    : 1.0 - initial release
// ============================================================================
package debounce_pkg;

    // Debounce FSM states. The IDLE_* encodings carry the committed level in
    // bit 1, and WAIT_* states differ from their IDLE_* origin in bit 0.
    typedef enum logic [1:0] {
        IDLE_LOW  = 2'b00,
        WAIT_HIGH = 2'b01,
        IDLE_HIGH = 2'b11,
        WAIT_LOW  = 2'b10
    } deb_state_e;

    // Default synchronizer depth (must be >= 2).
    localparam int unsigned DEF_SYNC_STAGES     = 2;
    // Default number of consecutive stable cycles needed to commit a change.
    localparam int unsigned DEF_DEBOUNCE_CYCLES = 16;

    // True while a candidate level change is being qualified.
    function automatic logic is_wait_state(input deb_state_e st);
        return (st == WAIT_HIGH) || (st == WAIT_LOW);
    endfunction

endpackage : debounce_pkg
`default_nettype wire

// File: rtl/sync_ff.sv
`default_nettype none
// ============================================================================
// Module      : sync_ff
// Description : Plain N-flop synchronizer for a single asynchronous level.
//               No logic is placed between stages so that each flop gets a
//               full clock period to resolve metastability.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_ff #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain_q;

    // Shift the asynchronous input through the flop chain; reset clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain_q <= '0;
        end else begin
            chain_q <= {chain_q[STAGES-2:0], d};
        end
    end

    assign q = chain_q[STAGES-1];

endmodule : sync_ff
`default_nettype wire

// File: rtl/button_debouncer.sv
`default_nettype none
// ============================================================================
// Module      : button_debouncer
// Description : Turns a bouncy asynchronous button level into a clean,
//               registered level in the clk domain. The raw input is first
//               synchronized, then a 4-state FSM only commits a new level
//               after it has been seen stable for DEBOUNCE_CYCLES cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module button_debouncer
    import debounce_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_in,
    output logic btn_clean,
    output logic busy
);

    // Counter just wide enough to reach DEBOUNCE_CYCLES-1.
    localparam int unsigned      CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             btn_sync;
    deb_state_e       state_q,  state_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic             clean_q,  clean_d;
    logic             busy_q,   busy_d;

    // Bring the raw button level into the clk domain.
    sync_ff #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (btn_in),
        .q     (btn_sync)
    );

    // Next-state, counter and output decisions. The counter defaults to 0 so
    // that every IDLE state and every abort restarts qualification from scratch.
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        clean_d = clean_q;

        case (state_q)
            IDLE_LOW: begin
                if (btn_sync) begin
                    state_d = WAIT_HIGH;
                end
            end

            WAIT_HIGH: begin
                if (!btn_sync) begin
                    // Bounce back to the committed level: abandon the candidate.
                    state_d = IDLE_LOW;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE_HIGH;
                    clean_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            IDLE_HIGH: begin
                if (!btn_sync) begin
                    state_d = WAIT_LOW;
                end
            end

            WAIT_LOW: begin
                if (btn_sync) begin
                    state_d = IDLE_HIGH;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE_LOW;
                    clean_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            default: begin
                // Any corrupted encoding falls back to a known released button.
                state_d = IDLE_LOW;
                clean_d = 1'b0;
            end
        endcase

        // busy is derived from the next state so it is registered alongside it.
        busy_d = is_wait_state(state_d);
    end

    // State, counter and registered outputs; reset clears all immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE_LOW;
            cnt_q   <= '0;
            clean_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            clean_q <= clean_d;
            busy_q  <= busy_d;
        end
    end

    assign btn_clean = clean_q;
    assign busy      = busy_q;

endmodule : button_debouncer
`default_nettype wire
